// File: rtl/servo_waypoint_sequencer_pkg.sv
// Shared types, defaults and the per-axis step helper for the servo waypoint sequencer.
package servo_seq_pkg;

  localparam int         FRAME_CYCLES_DEF = 1000000;
  localparam logic [7:0] STEP_DEF         = 8'd4;
  localparam logic [7:0] HOME_DEF         = 8'd128;
  localparam int         DEPTH_DEF        = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SLEW  = 2'd1,
    ST_DWELL = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic [7:0] pos_p;
    logic [7:0] pos_y;
    logic [7:0] dwell;
  } cmd_t;

  // Move one axis toward its target by at most step, landing exactly on target.
  // The gap is measured before adding/subtracting, so the 8-bit result never wraps.
  function automatic logic [7:0] step_toward(input logic [7:0] pos,
                                             input logic [7:0] target,
                                             input logic [7:0] step);
    logic [7:0] res;
    if (target >= pos)
      res = ((target - pos) <= step) ? target : pos + step;
    else
      res = ((pos - target) <= step) ? target : pos - step;
    return res;
  endfunction

endpackage

// File: rtl/servo_waypoint_sequencer_if.sv
// Waypoint command handshake between the command source and the sequencer.
interface servo_waypoint_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_pos_p;
  logic [7:0] cmd_pos_y;
  logic [7:0] cmd_dwell;

  modport master (output cmd_valid, output cmd_pos_p, output cmd_pos_y,
                  output cmd_dwell, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_pos_p, input cmd_pos_y,
                  input cmd_dwell, output cmd_ready);
endinterface

// File: rtl/servo_waypoint_sequencer_cmd_fifo.sv
// Waypoint command queue: DEPTH entries, head entry read straight from the storage flops.
module cmd_fifo
  import servo_seq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  cmd_t                     wdata,
  output cmd_t                     rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // flush wins over both ends; full/empty guard against misuse by the caller
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/servo_waypoint_sequencer.sv
// Frame-synchronous pan/tilt waypoint sequencer: frame timer, motion FSM, step datapath, load strobe.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | holding position, pops the next waypoint on a tick
//   ST_SLEW  | stepping both axes toward target, one step per tick
//   ST_DWELL | at target, counting dwell frames before the next waypoint
module servo_waypoint_sequencer
  import servo_seq_pkg::*;
#(
  parameter int         FRAME_CYCLES = FRAME_CYCLES_DEF,
  parameter logic [7:0] STEP         = STEP_DEF,
  parameter logic [7:0] HOME         = HOME_DEF,
  parameter int         DEPTH        = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    resetn,
  servo_waypoint_sequencer_if.slave cmd,
  input  logic                    flush,
  output logic [7:0]              pos_p,
  output logic [7:0]              pos_y,
  output logic                    load,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  q_count
);
  localparam int FW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

  seq_state_t    state;
  cmd_t          target;
  cmd_t          head;
  cmd_t          cmd_in;
  logic [7:0]    dwell_cnt;
  logic [FW-1:0] frame_cnt;
  logic          tick;
  logic          push;
  logic          pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    next_p;
  logic [7:0]    next_y;

  assign tick          = (frame_cnt == FW'(FRAME_CYCLES - 1));
  assign cmd.cmd_ready = !fifo_full;
  assign push          = cmd.cmd_valid && !fifo_full;
  assign cmd_in        = {cmd.cmd_pos_p, cmd.cmd_pos_y, cmd.cmd_dwell};
  assign next_p        = step_toward(pos_p, target.pos_p, STEP);
  assign next_y        = step_toward(pos_y, target.pos_y, STEP);

  // The FSM consumes the head exactly when this is high, so queue and FSM never disagree.
  assign pop = tick && !flush && !fifo_empty &&
               ((state == ST_IDLE) || ((state == ST_DWELL) && (dwell_cnt == 8'd0)));

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .flush  (flush),
    .wdata  (cmd_in),
    .rdata  (head),
    .count  (q_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Free-running frame timer; flush deliberately leaves it alone.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)   frame_cnt <= '0;
    else if (tick) frame_cnt <= '0;
    else           frame_cnt <= frame_cnt + FW'(1);
  end

  // PWM latch strobe: the cycle after every tick, when the new positions are already stable.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) load <= 1'b0;
    else         load <= tick;
  end

  // Motion FSM with registered positions and busy; busy is written alongside every state change.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      pos_p     <= HOME;
      pos_y     <= HOME;
      target    <= '0;
      dwell_cnt <= 8'd0;
    end else if (flush) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else if (tick) begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            target <= head;
            state  <= ST_SLEW;
            busy   <= 1'b1;
          end
        end
        ST_SLEW: begin
          pos_p <= next_p;
          pos_y <= next_y;
          if ((next_p == target.pos_p) && (next_y == target.pos_y)) begin
            dwell_cnt <= target.dwell;
            state     <= ST_DWELL;
          end
        end
        ST_DWELL: begin
          if (dwell_cnt != 8'd0) begin
            dwell_cnt <= dwell_cnt - 8'd1;
          end else if (pop) begin
            target <= head;
            state  <= ST_SLEW;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_servo_waypoint_sequencer.sv
// Directed, table-driven bench for servo_waypoint_sequencer with a 10-cycle frame.
module tb_servo_waypoint_sequencer;
  localparam int FRAME = 10;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       flush = 1'b0;
  logic [7:0] pos_p;
  logic [7:0] pos_y;
  logic       load;
  logic       busy;
  logic [2:0] q_count;

  servo_waypoint_sequencer_if cmd_bus ();

  servo_waypoint_sequencer #(
    .FRAME_CYCLES (FRAME),
    .STEP         (8'd4),
    .HOME         (8'd128),
    .DEPTH        (4)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .cmd     (cmd_bus),
    .flush   (flush),
    .pos_p   (pos_p),
    .pos_y   (pos_y),
    .load    (load),
    .busy    (busy),
    .q_count (q_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // mode: 0 = no command, 1 = push at frame start, 2 = push in the tick cycle
  typedef struct {
    int         mode;
    logic [7:0] cp, cy, cd;
    logic [7:0] ep, ey;
    logic       eb;
    int         eq;
  } row_t;

  row_t tv[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int mode, input int cp, input int cy, input int cd,
                     input int ep, input int ey, input int eb, input int eq);
    row_t r;
    r.mode = mode;
    r.cp = 8'(cp);
    r.cy = 8'(cy);
    r.cd = 8'(cd);
    r.ep = 8'(ep);
    r.ey = 8'(ey);
    r.eb = 1'(eb);
    r.eq = eq;
    tv.push_back(r);
  endtask

  // Advance to the next negedge where load is high; n = negedges taken.
  task automatic wait_load(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!load && n < 3 * FRAME);
    if (!load) check("load timeout", load, 1);
  endtask

  task automatic push(input int p, input int y, input int d, output int waited);
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_pos_p = 8'(p);
    cmd_bus.cmd_pos_y = 8'(y);
    cmd_bus.cmd_dwell = 8'(d);
    waited = 0;
    while (!cmd_bus.cmd_ready && waited < 4 * FRAME) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_bus.cmd_ready) check("push ready timeout", cmd_bus.cmd_ready, 1);
    @(negedge clk);
    cmd_bus.cmd_valid = 1'b0;
  endtask

  task automatic run_rows(input int first, input int last);
    int n, w;
    for (int i = first; i <= last; i++) begin
      if (tv[i].mode == 2) begin
        repeat (FRAME - 1) @(negedge clk);
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_pos_p = tv[i].cp;
        cmd_bus.cmd_pos_y = tv[i].cy;
        cmd_bus.cmd_dwell = tv[i].cd;
        check($sformatf("row%0d tick-cycle ready", i), cmd_bus.cmd_ready, 1);
        @(negedge clk);
        cmd_bus.cmd_valid = 1'b0;
        check($sformatf("row%0d load", i), load, 1);
      end else begin
        if (tv[i].mode == 1) push(tv[i].cp, tv[i].cy, tv[i].cd, w);
        wait_load(n);
      end
      check($sformatf("row%0d pos_p", i), pos_p, tv[i].ep);
      check($sformatf("row%0d pos_y", i), pos_y, tv[i].ey);
      check($sformatf("row%0d busy", i), busy, tv[i].eb);
      check($sformatf("row%0d q_count", i), q_count, tv[i].eq);
    end
  endtask

  initial begin
    int n, w;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_pos_p = 8'd0;
    cmd_bus.cmd_pos_y = 8'd0;
    cmd_bus.cmd_dwell = 8'd0;

    // single waypoint with dwell, then a descending non-multiple approach
    add(1, 140, 120, 2, 128, 128, 1, 0);   // 0
    add(0, 0, 0, 0, 132, 124, 1, 0);
    add(0, 0, 0, 0, 136, 120, 1, 0);
    add(0, 0, 0, 0, 140, 120, 1, 0);
    add(0, 0, 0, 0, 140, 120, 1, 0);
    add(0, 0, 0, 0, 140, 120, 1, 0);
    add(0, 0, 0, 0, 140, 120, 0, 0);
    add(1, 130, 2, 0, 140, 120, 1, 0);
    add(0, 0, 0, 0, 136, 116, 1, 0);
    add(0, 0, 0, 0, 132, 112, 1, 0);
    add(0, 0, 0, 0, 130, 108, 1, 0);       // 10
    // dwell 0 chained straight into the next waypoint, 2 -> 0 without wrap
    add(1, 130, 0, 0, 130, 2, 1, 0);       // 11
    add(0, 0, 0, 0, 130, 0, 1, 0);
    add(0, 0, 0, 0, 130, 0, 0, 0);         // 13
    // slew that gets flushed at 136
    add(1, 160, 128, 0, 128, 128, 1, 0);   // 14
    add(0, 0, 0, 0, 132, 128, 1, 0);
    add(0, 0, 0, 0, 136, 128, 1, 0);       // 16
    // ascending non-multiple
    add(1, 138, 128, 0, 136, 128, 1, 0);   // 17
    add(0, 0, 0, 0, 138, 128, 1, 0);
    add(0, 0, 0, 0, 138, 128, 0, 0);       // 19
    // queued A..E in order, F pushed on a popping tick
    add(0, 0, 0, 0, 142, 128, 1, 4);       // 20
    add(0, 0, 0, 0, 142, 128, 1, 3);
    add(0, 0, 0, 0, 146, 128, 1, 3);
    add(2, 162, 128, 0, 146, 128, 1, 3);
    add(0, 0, 0, 0, 150, 128, 1, 3);
    add(0, 0, 0, 0, 150, 128, 1, 2);
    add(0, 0, 0, 0, 154, 128, 1, 2);
    add(0, 0, 0, 0, 154, 128, 1, 1);
    add(0, 0, 0, 0, 158, 128, 1, 1);
    add(0, 0, 0, 0, 158, 128, 1, 0);
    add(0, 0, 0, 0, 162, 128, 1, 0);
    add(0, 0, 0, 0, 162, 128, 0, 0);       // 31

    repeat (3) @(negedge clk);
    check("reset pos_p", pos_p, 128);
    check("reset pos_y", pos_y, 128);
    check("reset load", load, 0);
    check("reset busy", busy, 0);
    check("reset cmd_ready", cmd_bus.cmd_ready, 1);
    check("reset q_count", q_count, 0);
    resetn = 1'b1;
    wait_load(n);
    check("first frame length", n, FRAME);

    run_rows(0, 10);
    repeat (27) wait_load(n);
    check("descend end pos_p", pos_p, 130);
    check("descend end pos_y", pos_y, 2);
    check("descend end busy", busy, 1);
    run_rows(11, 13);

    // asynchronous reset in the middle of a slew with one entry still queued
    push(200, 200, 5, w);
    push(210, 210, 0, w);
    wait_load(n);
    check("pre-reset pop q_count", q_count, 1);
    wait_load(n);
    check("pre-reset pos_p", pos_p, 134);
    check("pre-reset pos_y", pos_y, 4);
    repeat (3) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("async reset pos_p", pos_p, 128);
    check("async reset pos_y", pos_y, 128);
    check("async reset load", load, 0);
    check("async reset busy", busy, 0);
    check("async reset cmd_ready", cmd_bus.cmd_ready, 1);
    check("async reset q_count", q_count, 0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    wait_load(n);
    check("post-reset first frame", n, FRAME);
    wait_load(n);
    check("post-reset frame period", n, FRAME);
    check("post-reset idle pos_p", pos_p, 128);
    check("post-reset idle busy", busy, 0);

    run_rows(14, 16);
    push(200, 200, 0, w);
    check("pre-flush q_count", q_count, 1);
    flush = 1'b1;
    cmd_bus.cmd_valid = 1'b1;
    cmd_bus.cmd_pos_p = 8'd10;
    cmd_bus.cmd_pos_y = 8'd10;
    cmd_bus.cmd_dwell = 8'd0;
    @(negedge clk);
    flush = 1'b0;
    cmd_bus.cmd_valid = 1'b0;
    check("flush q_count", q_count, 0);
    check("flush busy", busy, 0);
    wait_load(n);
    check("flush hold pos_p", pos_p, 136);
    check("flush hold pos_y", pos_y, 128);
    check("flush hold busy", busy, 0);
    wait_load(n);
    check("flush hold2 pos_p", pos_p, 136);
    check("flush hold2 q_count", q_count, 0);

    run_rows(17, 19);
    push(142, 128, 0, w);
    push(146, 128, 0, w);
    push(150, 128, 0, w);
    push(154, 128, 0, w);
    check("full cmd_ready", cmd_bus.cmd_ready, 0);
    check("full q_count", q_count, 4);
    push(158, 128, 0, w);
    check("fifth push wait", w, 6);
    check("refill q_count", q_count, 4);
    check("refill busy", busy, 1);
    check("refill pos_p", pos_p, 138);
    run_rows(20, 31);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
